fc_layer_link: RTL and testbench

//  Inter-layer glue between two fc_layer instances. Consumes the serial activation stream of layer N,

---
 rtl/fc_pkg.sv | 31 +++
 rtl/fc_layer_link_if.sv | 28 ++
 rtl/fc_requant.sv | 19 +
 rtl/fc_layer_link.sv | 97 +++++++++
 tb/tb_fc_layer_link.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/fc_pkg.sv
// rtl/fc_pkg.sv - shared link state type and requantisation helper for the fc layer link
package fc_pkg;

  typedef enum logic [1:0] {IDLE, FILL, ISSUE, WAIT_ACK} link_state_t;

  localparam int REQ_W = 32;

  // Arithmetic shift, then clamp to the unsigned (relu) or signed range of out_w bits.
  function automatic logic signed [REQ_W-1:0] requant(
    input logic signed [REQ_W-1:0] value,
    input int                      sh,
    input logic                    relu_en,
    input int                      out_w
  );
    logic signed [REQ_W-1:0] s;
    logic signed [REQ_W-1:0] hi;
    logic signed [REQ_W-1:0] lo;
    s = value >>> sh;
    if (relu_en) begin
      hi = (32'sd1 <<< out_w) - 32'sd1;
      lo = '0;
    end else begin
      hi = (32'sd1 <<< (out_w - 1)) - 32'sd1;
      lo = -(32'sd1 <<< (out_w - 1));
    end
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

endpackage

// File: rtl/fc_layer_link_if.sv
// rtl/fc_layer_link_if.sv - activation stream, next-layer ibuf write and start handshake bundle
interface fc_layer_link_if #(
  parameter int datatype_size    = 8,
  parameter int in_datatype_size = 16,
  parameter int vec_size         = 784
);
  localparam int addr_w = $clog2(vec_size);

  logic                        i_valid;
  logic [in_datatype_size-1:0] i_data;
  logic                        o_next_busy;
  logic                        o_ibuf_we;
  logic [datatype_size-1:0]    o_ibuf_wr_data;
  logic [addr_w-1:0]           o_ibuf_addr;
  logic                        o_start;
  logic                        i_ds_busy;
  logic                        o_overrun;

  modport slave (
    input  i_valid, i_data, i_ds_busy,
    output o_next_busy, o_ibuf_we, o_ibuf_wr_data, o_ibuf_addr, o_start, o_overrun
  );

  modport master (
    output i_valid, i_data, i_ds_busy,
    input  o_next_busy, o_ibuf_we, o_ibuf_wr_data, o_ibuf_addr, o_start, o_overrun
  );
endinterface

// File: rtl/fc_requant.sv
// rtl/fc_requant.sv - combinational ReLU/shift/saturate of one layer-N element
module fc_requant
  import fc_pkg::*;
#(
  parameter int in_datatype_size = 16,
  parameter int datatype_size    = 8,
  parameter int shift            = 8,
  parameter int relu             = 1
) (
  input  logic signed [in_datatype_size-1:0] i_value,
  output logic        [datatype_size-1:0]    o_value
);

  logic signed [REQ_W-1:0] w_ext;

  assign w_ext   = REQ_W'(i_value);
  assign o_value = datatype_size'(requant(w_ext, shift, relu != 0, datatype_size));

endmodule

// File: rtl/fc_layer_link.sv
// rtl/fc_layer_link.sv - requantises layer N output into layer N+1 ibuf and issues its start
module fc_layer_link
  import fc_pkg::*;
#(
  parameter int datatype_size    = 8,
  parameter int in_datatype_size = 16,
  parameter int vec_size         = 784,
  parameter int shift            = 8,
  parameter int relu             = 1
) (
  input  logic            clk,
  input  logic            rst,
  fc_layer_link_if.slave  io_link
);

  localparam int                addr_w    = $clog2(vec_size);
  localparam logic [addr_w-1:0] last_addr = addr_w'(vec_size - 1);

  link_state_t              r_state;
  logic [addr_w-1:0]        r_cnt;
  logic [addr_w-1:0]        r_addr;
  logic [datatype_size-1:0] r_wr_data;
  logic                     r_we;
  logic                     r_start;
  logic                     r_overrun;
  logic [datatype_size-1:0] w_requant;
  logic                     w_next_busy;
  logic                     w_accept;
  logic                     w_last;

  fc_requant #(
    .in_datatype_size (in_datatype_size),
    .datatype_size    (datatype_size),
    .shift            (shift),
    .relu             (relu)
  ) u_requant (
    .i_value (io_link.i_data),
    .o_value (w_requant)
  );

  // In IDLE a busy layer N+1 is still reading the ibuf, so hold data off.
  always_comb begin
    w_next_busy = 1'b1;
    case (r_state)
      IDLE:    w_next_busy = io_link.i_ds_busy;
      FILL:    w_next_busy = 1'b0;
      default: w_next_busy = 1'b1;
    endcase
  end

  assign w_accept = io_link.i_valid && !w_next_busy;
  assign w_last   = (r_cnt == last_addr);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_addr    <= '0;
      r_wr_data <= '0;
      r_we      <= 1'b0;
      r_start   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_we      <= w_accept;
      r_start   <= 1'b0;
      r_overrun <= r_overrun | (io_link.i_valid & w_next_busy);
      if (w_accept) begin
        r_wr_data <= w_requant;
        r_addr    <= r_cnt;
        r_cnt     <= w_last ? '0 : r_cnt + 1'b1;
      end
      case (r_state)
        IDLE, FILL: begin
          if (w_accept) r_state <= w_last ? ISSUE : FILL;
        end
        ISSUE: begin
          if (!io_link.i_ds_busy) begin
            r_start <= 1'b1;
            r_state <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (io_link.i_ds_busy) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign io_link.o_next_busy    = w_next_busy;
  assign io_link.o_ibuf_we      = r_we;
  assign io_link.o_ibuf_wr_data = r_wr_data;
  assign io_link.o_ibuf_addr    = r_addr;
  assign io_link.o_start        = r_start;
  assign io_link.o_overrun      = r_overrun;

endmodule

// File: tb/tb_fc_layer_link.sv
// tb/tb_fc_layer_link.sv - scoreboard bench for fc_layer_link across three parameter sets
module tb_fc_layer_link;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  int sb[3][$];
  int starts[3];
  int start_cyc[3];
  int last_we_cyc[3];
  int writes[3];

  logic [15:0] t1 [4] = '{16'h0100, 16'h7FFF, 16'hFF00, 16'h0280};
  logic [15:0] t2 [3] = '{16'h0800, 16'hF800, 16'h0070};

  fc_layer_link_if #(.datatype_size(8), .in_datatype_size(16), .vec_size(4))   ifa ();
  fc_layer_link_if #(.datatype_size(8), .in_datatype_size(16), .vec_size(3))   ifb ();
  fc_layer_link_if #(.datatype_size(8), .in_datatype_size(16), .vec_size(784)) ifc ();

  fc_layer_link #(.datatype_size(8), .in_datatype_size(16), .vec_size(4), .shift(8), .relu(1))
    dut_a (.clk(clk), .rst(rst), .io_link(ifa.slave));
  fc_layer_link #(.datatype_size(8), .in_datatype_size(16), .vec_size(3), .shift(4), .relu(0))
    dut_b (.clk(clk), .rst(rst), .io_link(ifb.slave));
  fc_layer_link #(.datatype_size(8), .in_datatype_size(16), .vec_size(784), .shift(8), .relu(1))
    dut_c (.clk(clk), .rst(rst), .io_link(ifc.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_rq(input int k, input logic [15:0] d);
    int s;
    s = int'($signed(d)) >>> ((k == 1) ? 4 : 8);
    if (k == 1) begin
      if (s > 127) s = 127;
      else if (s < -128) s = -128;
    end else begin
      if (s < 0) s = 0;
      else if (s > 255) s = 255;
    end
    return s & 255;
  endfunction

  task automatic mon_one(input int k, input logic we, input int addr, input int data, input logic start);
    int exp;
    if (we) begin
      writes[k]++;
      last_we_cyc[k] = cycle;
      if (sb[k].size() == 0) chk($sformatf("dut%0d_unexpected_we", k), 32'(we), 32'd0);
      else begin
        exp = sb[k].pop_front();
        chk($sformatf("dut%0d_write_addr_data", k), addr * 256 + data, exp);
      end
    end
    if (start) begin
      starts[k]++;
      start_cyc[k] = cycle;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    cycle++;
    mon_one(0, ifa.o_ibuf_we, int'(ifa.o_ibuf_addr), int'(ifa.o_ibuf_wr_data), ifa.o_start);
    mon_one(1, ifb.o_ibuf_we, int'(ifb.o_ibuf_addr), int'(ifb.o_ibuf_wr_data), ifb.o_start);
    mon_one(2, ifc.o_ibuf_we, int'(ifc.o_ibuf_addr), int'(ifc.o_ibuf_wr_data), ifc.o_start);
  endtask

  task automatic drv(input int k, input logic v, input logic [15:0] d);
    case (k)
      0:       begin ifa.i_valid = v; ifa.i_data = d; end
      1:       begin ifb.i_valid = v; ifb.i_data = d; end
      default: begin ifc.i_valid = v; ifc.i_data = d; end
    endcase
  endtask

  task automatic ds(input int k, input logic b);
    case (k)
      0:       ifa.i_ds_busy = b;
      1:       ifb.i_ds_busy = b;
      default: ifc.i_ds_busy = b;
    endcase
  endtask

  task automatic send(input int k, input int idx, input logic [15:0] d);
    drv(k, 1'b1, d);
    sb[k].push_back(idx * 256 + ref_rq(k, d));
    cyc();
  endtask

  task automatic wait_start(input int k, input int budget, input string tag);
    int s0;
    s0 = starts[k];
    for (int n = 0; n < budget && starts[k] == s0; n++) cyc();
    chk(tag, starts[k], s0 + 1);
  endtask

  task automatic ack(input int k);
    ds(k, 1'b1);
    cyc();
    cyc();
    ds(k, 1'b0);
    cyc();
  endtask

  initial begin
    int s0;
    int rel;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drv(k, 1'b0, 16'h0);
      ds(k, 1'b0);
    end
    repeat (3) cyc();
    rst = 1'b0;
    cyc();
    chk("reset_we", 32'(ifa.o_ibuf_we), 32'd0);
    chk("reset_start", 32'(ifa.o_start), 32'd0);
    chk("reset_addr", 32'(ifa.o_ibuf_addr), 32'd0);
    chk("reset_overrun", 32'(ifa.o_overrun), 32'd0);
    chk("reset_next_busy", 32'(ifa.o_next_busy), 32'd0);
    chk("reset_c_next_busy", 32'(ifc.o_next_busy), 32'd0);

    for (int i = 0; i < 4; i++) send(0, i, t1[i]);
    drv(0, 1'b0, 16'h0);
    cyc();
    chk("t1_starts", starts[0], 1);
    chk("t1_start_after_last_write", start_cyc[0] - last_we_cyc[0], 1);
    chk("t1_busy_wait_ack", 32'(ifa.o_next_busy), 32'd1);
    ack(0);
    chk("t1_idle_ready", 32'(ifa.o_next_busy), 32'd0);

    for (int i = 0; i < 3; i++) send(1, i, t2[i]);
    drv(1, 1'b0, 16'h0);
    wait_start(1, 10, "t2_start");
    ack(1);

    for (int i = 0; i < 3; i++) send(0, i, 16'(i * 300));
    ds(0, 1'b1);
    send(0, 3, 16'h1234);
    drv(0, 1'b0, 16'h0);
    s0 = starts[0];
    repeat (4) cyc();
    chk("t3_no_early_start", starts[0], s0);
    ds(0, 1'b0);
    rel = cycle;
    cyc();
    chk("t3_start_count", starts[0], s0 + 1);
    chk("t3_start_after_release", start_cyc[0] - rel, 1);
    ack(0);
    chk("t3_overrun_clear", 32'(ifa.o_overrun), 32'd0);

    ds(0, 1'b1);
    cyc();
    drv(0, 1'b1, 16'h1234);
    cyc();
    chk("t4_busy_in_idle", 32'(ifa.o_next_busy), 32'd1);
    chk("t4_overrun_set", 32'(ifa.o_overrun), 32'd1);
    drv(0, 1'b0, 16'h0);
    cyc();
    drv(0, 1'b1, 16'h0100);
    cyc();
    drv(0, 1'b0, 16'h0);
    ds(0, 1'b0);
    repeat (3) cyc();
    chk("t4_overrun_sticky", 32'(ifa.o_overrun), 32'd1);
    chk("t4_ready_after_release", 32'(ifa.o_next_busy), 32'd0);

    for (int v = 0; v < 2; v++) begin
      for (int i = 0; i < 784; i++) send(2, i, 16'($urandom));
      drv(2, 1'b0, 16'h0);
      wait_start(2, 10, "t5_start");
      cyc();
      ack(2);
      chk("t5_ready", 32'(ifc.o_next_busy), 32'd0);
    end
    chk("t5_starts", starts[2], 2);
    chk("t5_writes", writes[2], 1568);
    chk("t5_overrun", 32'(ifc.o_overrun), 32'd0);

    for (int i = 0; i < 3; i++) send(0, i, 16'(16'h0200 + i * 16'h0100));
    drv(0, 1'b0, 16'h0);
    chk("t6_overrun_before_rst", 32'(ifa.o_overrun), 32'd1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("t6_addr_after_rst", 32'(ifa.o_ibuf_addr), 32'd0);
    chk("t6_overrun_after_rst", 32'(ifa.o_overrun), 32'd0);
    s0 = starts[0];
    for (int i = 0; i < 4; i++) send(0, i, 16'(16'h0A00 + i * 16'h0100));
    drv(0, 1'b0, 16'h0);
    wait_start(0, 10, "t6_start");
    chk("t6_start_after_last_write", start_cyc[0] - last_we_cyc[0], 1);
    ack(0);
    repeat (5) cyc();
    chk("t6_single_start", starts[0], s0 + 1);

    for (int k = 0; k < 3; k++) chk($sformatf("sb%0d_drained", k), sb[k].size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
